// File: rtl/uart_frame_tx.sv
// Serialises pre-built 10-bit UART frames {stop, data, start} onto tx at the baud rate,
// with an idle guard time after each frame and rejection of malformed frames.
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int GAP_BITS     = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ivalid,
  input  logic [9:0] idata,
  output logic       iready,
  output logic       tx,
  output logic       busy,
  output logic       ferr
);

  localparam int             BW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     GAP_LAST  = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam bit             GAP_ONE   = ((GAP_BITS * CLKS_PER_BIT) == 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state_q;
  logic [8:0]      shreg_q;
  logic [BW-1:0]   baud_q;
  logic [BW-1:0]   baud_d;
  logic [3:0]      bit_q;
  logic [3:0]      bit_d;
  logic            baud_wrap;
  logic            tx_q;
  logic            iready_q;
  logic            busy_q;
  logic            ferr_q;
  logic            xfer;
  logic            frame_ok;

  assign xfer     = ivalid && iready_q;
  assign frame_ok = ~idata[0] & idata[9];

  always_comb begin
    baud_wrap = (baud_q == BAUD_LAST);
    baud_d    = baud_wrap ? '0 : baud_q + 1'b1;
    bit_d     = baud_wrap ? bit_q + 4'd1 : bit_q;
  end

  // The final line-high cycle of a frame (stop bit or guard) is spent in IDLE with
  // iready raised, so a waiting frame is accepted exactly (10+GAP_BITS)*CLKS_PER_BIT
  // cycles after the previous one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      iready_q <= 1'b1;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (frame_ok) begin
              shreg_q  <= idata[9:1];
              tx_q     <= idata[0];
              baud_q   <= '0;
              bit_q    <= '0;
              iready_q <= 1'b0;
              busy_q   <= 1'b1;
              state_q  <= SHIFT;
            end else begin
              ferr_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          baud_q <= baud_d;
          bit_q  <= bit_d;
          if (baud_wrap) begin
            shreg_q <= {1'b1, shreg_q[8:1]};
            tx_q    <= shreg_q[0];
          end
          if (GAP_BITS == 0) begin
            if (bit_d == 4'd9 && baud_d == BAUD_LAST) begin
              tx_q     <= 1'b1;
              baud_q   <= '0;
              bit_q    <= '0;
              iready_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end
          end else if (baud_wrap && bit_q == 4'd9) begin
            tx_q   <= 1'b1;
            baud_q <= '0;
            bit_q  <= '0;
            if (GAP_ONE) begin
              iready_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end else begin
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          baud_q <= baud_d;
          bit_q  <= bit_d;
          if (bit_d == GAP_LAST && baud_d == BAUD_LAST) begin
            baud_q   <= '0;
            bit_q    <= '0;
            iready_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          tx_q     <= 1'b1;
          iready_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign tx     = tx_q;
  assign iready = iready_q;
  assign busy   = busy_q;
  assign ferr   = ferr_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: one instance at 4 clocks/bit with one guard bit,
// one at 1 clock/bit with no guard time.
module tb_uart_frame_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ivalid, ivalid_e;
  logic [9:0] idata, idata_e;
  logic       iready, tx, busy, ferr;
  logic       iready_e, tx_e, busy_e, ferr_e;

  int n_chk  = 0;
  int n_pass = 0;

  logic txa [128];
  logic rda [128];
  logic bsa [128];
  logic fea [128];
  logic txb [128];

  always #5 clk = ~clk;

  uart_frame_tx #(.CLKS_PER_BIT(4), .GAP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .ivalid(ivalid), .idata(idata),
    .iready(iready), .tx(tx), .busy(busy), .ferr(ferr)
  );

  uart_frame_tx #(.CLKS_PER_BIT(1), .GAP_BITS(0)) dut_e (
    .clk(clk), .reset_n(reset_n), .ivalid(ivalid_e), .idata(idata_e),
    .iready(iready_e), .tx(tx_e), .busy(busy_e), .ferr(ferr_e)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic geta(input int i);
    return (i >= 0 && i < 128) ? txa[i] : 1'bx;
  endfunction

  function automatic logic getb(input int i);
    return (i >= 0 && i < 128) ? txb[i] : 1'bx;
  endfunction

  // Data byte of a 4-clock/bit frame starting at log index t, sampled mid-bit.
  function automatic logic [7:0] deca(input int t);
    logic [7:0] d;
    for (int j = 0; j < 8; j++) d[j] = geta(t + 2 + 4 * (j + 1));
    return d;
  endfunction

  initial begin
    logic [9:0] f;
    logic [9:0] v;
    logic [9:0] q[$];
    int cnt, cnt2, cnt3, cnt4, nacc;
    int tacc[2];
    logic fire;

    reset_n  = 1'b0;
    ivalid   = 1'b0;
    idata    = '0;
    ivalid_e = 1'b0;
    idata_e  = '0;

    // 1: reset values, then idle line
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_iready", iready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    reset_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx === 1'b1) cnt++;
    end
    chk("idle_tx_high_cycles", cnt, 20);

    // 2: single frame 0x2AA
    f = 10'h2AA;
    ivalid = 1'b1;
    idata  = f;
    tick();
    ivalid = 1'b0;
    idata  = '0;
    for (int c = 0; c < 48; c++) begin
      txa[c] = tx; rda[c] = iready; bsa[c] = busy; fea[c] = ferr;
      tick();
    end
    for (int i = 0; i < 10; i++) chk($sformatf("single_bit%0d", i), txa[2 + 4 * i], f[i]);
    cnt = 0; cnt2 = 0; cnt3 = 0; cnt4 = 0;
    for (int c = 0; c < 48; c++) begin
      if (c >= 40 && c <= 43 && txa[c] === 1'b1) cnt++;
      if (rda[c] === 1'b0) cnt2++;
      if (bsa[c] !== ~rda[c]) cnt3++;
      if (fea[c] !== 1'b0) cnt4++;
    end
    chk("single_gap_high", cnt, 4);
    chk("single_iready_low_cycles", cnt2, 43);
    chk("single_iready_back", rda[43], 1'b1);
    chk("single_busy_mirror_errs", cnt3, 0);
    chk("single_ferr_cycles", cnt4, 0);

    // 3: back-to-back from a FIFO model with ivalid held
    q = '{10'h2AA, 10'h3FE};
    nacc = 0;
    tacc = '{0, 0};
    for (int c = 0; c < 120; c++) begin
      ivalid = (q.size() != 0);
      idata  = ivalid ? q[0] : 10'h000;
      fire   = ivalid && (iready === 1'b1);
      tick();
      if (fire) begin
        void'(q.pop_front());
        if (nacc < 2) tacc[nacc] = c;
        nacc++;
      end
      txa[c] = tx;
    end
    ivalid = 1'b0;
    chk("b2b_accepts", nacc, 2);
    chk("b2b_accept_spacing", tacc[1] - tacc[0], 44);
    chk("b2b_line_before_start2", geta(tacc[0] + 43), 1'b1);
    chk("b2b_start2", geta(tacc[0] + 44), 1'b0);
    chk("b2b_byte0", deca(tacc[0]), 8'h55);
    chk("b2b_byte1", deca(tacc[1]), 8'hFF);

    // 4: malformed frame, then a good one
    ivalid = 1'b1;
    idata  = 10'h000;
    tick();
    ivalid = 1'b0;
    chk("bad_ferr", ferr, 1'b1);
    chk("bad_tx", tx, 1'b1);
    chk("bad_iready", iready, 1'b1);
    chk("bad_busy", busy, 1'b0);
    tick();
    chk("bad_ferr_one_cycle", ferr, 1'b0);
    ivalid = 1'b1;
    idata  = 10'h2AA;
    tick();
    ivalid = 1'b0;
    for (int c = 0; c < 44; c++) begin
      txa[c] = tx; fea[c] = ferr;
      tick();
    end
    cnt = 0;
    for (int c = 0; c < 44; c++) if (fea[c] !== 1'b0) cnt++;
    chk("after_bad_ferr_cycles", cnt, 0);
    chk("after_bad_start", txa[0], 1'b0);
    chk("after_bad_byte", deca(0), 8'h55);

    // 5: reset during bit 4
    ivalid = 1'b1;
    idata  = 10'h2AA;
    tick();
    ivalid = 1'b0;
    repeat (17) tick();
    chk("mid_bit4_tx", tx, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx_async", tx, 1'b1);
    chk("mid_rst_iready", iready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cnt = 0; cnt2 = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (tx !== 1'b1) cnt++;
      if (iready !== 1'b1) cnt2++;
    end
    chk("post_rst_tx_low_cycles", cnt, 0);
    chk("post_rst_iready_low_cycles", cnt2, 0);

    // 6: one clock per bit, no guard time
    q = '{10'h2AA, 10'h2AA};
    nacc = 0;
    tacc = '{0, 0};
    for (int c = 0; c < 40; c++) begin
      ivalid_e = (q.size() != 0);
      idata_e  = ivalid_e ? q[0] : 10'h000;
      fire     = ivalid_e && (iready_e === 1'b1);
      tick();
      if (fire) begin
        void'(q.pop_front());
        if (nacc < 2) tacc[nacc] = c;
        nacc++;
      end
      txb[c] = tx_e;
    end
    ivalid_e = 1'b0;
    chk("edge_accepts", nacc, 2);
    chk("edge_accept_spacing", tacc[1] - tacc[0], 10);
    for (int i = 0; i < 10; i++) v[i] = getb(tacc[0] + i);
    chk("edge_frame0_bits", v, 10'h2AA);
    for (int i = 0; i < 10; i++) v[i] = getb(tacc[1] + i);
    chk("edge_frame1_bits", v, 10'h2AA);
    chk("edge_idle_after", getb(tacc[1] + 10), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
